// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 pipeline sequencer.
// The ERR state exists only when ARC4_SCHED_WDOG_EN is defined.
package arc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int KEY_W   = 24;
    localparam int ADDR_W  = $clog2(S_DEPTH);
    localparam int DATA_W  = 8;

    // Owner of the single S-memory port.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        INIT = 2'd1,
        KSA  = 2'd2,
        PRGA = 2'd3
    } phase_t;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        START_INIT = 4'd1,
        WAIT_INIT  = 4'd2,
        START_KSA  = 4'd3,
        WAIT_KSA   = 4'd4,
        START_PRGA = 4'd5,
        WAIT_PRGA  = 4'd6,
`ifdef ARC4_SCHED_WDOG_EN
        FIN        = 4'd7,
        ERR        = 4'd8
`else
        FIN        = 4'd7
`endif
    } sched_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wrdata;
        logic              wren;
    } s_port_t;

endpackage

// File: rtl/arc4_sched_s_port_mux.sv
// Combinational 3-to-1 S-memory port mux; only the engine named by phase
// reaches the memory, and phase NONE drives an idle (all-zero) port.
module s_port_mux
    import arc4_pkg::*;
(
    input  phase_t  phase,
    input  s_port_t init_port,
    input  s_port_t ksa_port,
    input  s_port_t prga_port,
    output s_port_t s_port
);

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely
        // combinational; a path that leaves s_port unassigned would infer a latch.
        s_port = '0;
        case (phase)
            INIT:    s_port = init_port;
            KSA:     s_port = ksa_port;
            PRGA:    s_port = prga_port;
            default: s_port = '0;
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 sequencer: runs init, ksa, prga in order and arbitrates the S port.
// Optional engine watchdog compiled in with ARC4_SCHED_WDOG_EN.
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    input  logic [KEY_W-1:0]  key,
    output logic [KEY_W-1:0]  key_q,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase,
    output logic              init_en,
    output logic              ksa_en,
    output logic              prga_en,
    input  logic              init_rdy,
    input  logic              ksa_rdy,
    input  logic              prga_rdy,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] init_wrdata,
    input  logic [DATA_W-1:0] ksa_wrdata,
    input  logic [DATA_W-1:0] prga_wrdata,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren
);

    sched_state_t state;
    phase_t       phase_q;
    logic         busy_seen;
    logic         cur_rdy;

`ifdef ARC4_SCHED_WDOG_EN
    localparam logic [12:0] WDOG_LAST = 13'(WDOG_CYCLES - 1);
    logic [12:0] wdog;
    logic        err_q;
    assign err = err_q;
`else
    // The timeout limit has no meaning without the watchdog.
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = ^WDOG_CYCLES;
    assign err = 1'b0;
`endif

    assign phase = phase_q;

    // Ready of whichever engine the controller is currently waiting on.
    always_comb begin
        cur_rdy = 1'b0;
        case (state)
            WAIT_INIT: cur_rdy = init_rdy;
            WAIT_KSA:  cur_rdy = ksa_rdy;
            WAIT_PRGA: cur_rdy = prga_rdy;
            default:   cur_rdy = 1'b0;
        endcase
    end

    // Outputs are registered and set on the transition into the state that
    // owns them, so each x_en is high exactly during its START_x cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with <= only, so every
            // register here samples pre-edge values regardless of order.
            state     <= IDLE;
            rdy       <= 1'b1;
            done      <= 1'b0;
            phase_q   <= NONE;
            init_en   <= 1'b0;
            ksa_en    <= 1'b0;
            prga_en   <= 1'b0;
            key_q     <= '0;
            busy_seen <= 1'b0;
`ifdef ARC4_SCHED_WDOG_EN
            wdog      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            init_en <= 1'b0;
            ksa_en  <= 1'b0;
            prga_en <= 1'b0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (en) begin
                        key_q   <= key;
                        rdy     <= 1'b0;
                        phase_q <= INIT;
                        init_en <= 1'b1;
                        state   <= START_INIT;
                    end
                end

                START_INIT, START_KSA, START_PRGA: begin
                    busy_seen <= 1'b0;
`ifdef ARC4_SCHED_WDOG_EN
                    wdog      <= '0;
`endif
                    case (state)
                        START_INIT: state <= WAIT_INIT;
                        START_KSA:  state <= WAIT_KSA;
                        default:    state <= WAIT_PRGA;
                    endcase
                end

                WAIT_INIT, WAIT_KSA, WAIT_PRGA: begin
                    // Completion needs a busy cycle first; a ready engine that
                    // has not yet reacted to its start pulse is not finished.
                    if (busy_seen && cur_rdy) begin
                        case (state)
                            WAIT_INIT: begin
                                phase_q <= KSA;
                                ksa_en  <= 1'b1;
                                state   <= START_KSA;
                            end
                            WAIT_KSA: begin
                                phase_q <= PRGA;
                                prga_en <= 1'b1;
                                state   <= START_PRGA;
                            end
                            default: begin
                                phase_q <= NONE;
                                done    <= 1'b1;
                                state   <= FIN;
                            end
                        endcase
                    end else begin
                        if (!cur_rdy) begin
                            busy_seen <= 1'b1;
                        end
`ifdef ARC4_SCHED_WDOG_EN
                        if (wdog == WDOG_LAST) begin
                            phase_q <= NONE;
                            err_q   <= 1'b1;
                            state   <= ERR;
                        end else begin
                            wdog <= wdog + 13'd1;
                        end
`endif
                    end
                end

                FIN: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end

`ifdef ARC4_SCHED_WDOG_EN
                ERR: begin
                    // Sticky until reset; the port stays released.
                    rdy     <= 1'b0;
                    phase_q <= NONE;
                end
`endif

                default: begin
                    rdy     <= 1'b1;
                    phase_q <= NONE;
                    state   <= IDLE;
                end
            endcase
        end
    end

    s_port_t init_port;
    s_port_t ksa_port;
    s_port_t prga_port;
    s_port_t s_port;

    assign init_port = '{addr: init_addr, wrdata: init_wrdata, wren: init_wren};
    assign ksa_port  = '{addr: ksa_addr,  wrdata: ksa_wrdata,  wren: ksa_wren};
    assign prga_port = '{addr: prga_addr, wrdata: prga_wrdata, wren: prga_wren};

    s_port_mux u_s_port_mux (
        .phase     (phase_q),
        .init_port (init_port),
        .ksa_port  (ksa_port),
        .prga_port (prga_port),
        .s_port    (s_port)
    );

    assign s_addr   = s_port.addr;
    assign s_wrdata = s_port.wrdata;
    assign s_wren   = s_port.wren;

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: stub engines, a timeline model of the run, and
// directed scenarios (order, mux isolation, ignored en, mid-run reset, watchdog).
`timescale 1ns/1ps
module tb_arc4_sched;

`ifdef ARC4_SCHED_WDOG_EN
    localparam int WDOG   = 100;
    localparam int B_INIT = 20;
    localparam int B_KSA  = 40;
    localparam int B_PRGA = 10;
    // Hand-computed spacings from init_en: ksa_en, prga_en, done.
    localparam int LIT_KSA  = 22;
    localparam int LIT_PRGA = 66;
    localparam int LIT_DONE = 78;
`else
    localparam int WDOG   = 4096;
    localparam int B_INIT = 256;
    localparam int B_KSA  = 1024;
    localparam int B_PRGA = 64;
    localparam int LIT_KSA  = 258;
    localparam int LIT_PRGA = 1286;
    localparam int LIT_DONE = 1352;
`endif
    localparam int D_KSA = 2;   // ksa stub stays ready this long after its start pulse

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] key;
    logic        rdy, done, err;
    logic [1:0]  phase;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;
    logic [23:0] key_q;

    always #5 clk = ~clk;

    // ---------------- stub engines ----------------
    int t_init = 0, t_ksa = 0, t_prga = 0;
    bit prga_hang = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            t_init <= 0;
            t_ksa  <= 0;
            t_prga <= 0;
        end else begin
            if (init_en) t_init <= B_INIT;
            else if (t_init > 0) t_init <= t_init - 1;
            if (ksa_en) t_ksa <= D_KSA + B_KSA;
            else if (t_ksa > 0) t_ksa <= t_ksa - 1;
            if (prga_en) t_prga <= B_PRGA;
            else if (t_prga > 0) t_prga <= t_prga - 1;
        end
    end

    assign init_rdy = (t_init == 0);
    assign ksa_rdy  = (t_ksa == 0) || (t_ksa > B_KSA);
    assign prga_rdy = prga_hang ? 1'b0 : (t_prga == 0);

    arc4_sched #(.WDOG_CYCLES(WDOG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rdy         (rdy),
        .key         (key),
        .key_q       (key_q),
        .done        (done),
        .err         (err),
        .phase       (phase),
        .init_en     (init_en),
        .ksa_en      (ksa_en),
        .prga_en     (prga_en),
        .init_rdy    (init_rdy),
        .ksa_rdy     (ksa_rdy),
        .prga_rdy    (prga_rdy),
        .init_addr   (8'h11),
        .ksa_addr    (8'h22),
        .prga_addr   (8'h33),
        .init_wrdata (8'hA1),
        .ksa_wrdata  (8'hB2),
        .prga_wrdata (8'hC3),
        .init_wren   (1'b1),
        .ksa_wren    (1'b1),
        .prga_wren   (1'b1),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: an accepted start fixes the cycle of every later event
    // from the stub timings (each engine finishes 2+delay+busy after its pulse).
    bit          m_active = 1'b0;
    int          m_e_init, m_e_ksa, m_e_prga, m_e_done;
    logic [23:0] m_key = '0;

    function automatic bit m_idle(input int c);
        return !m_active || (c > m_e_done);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_key    <= '0;
        end else if (en && m_idle(cyc)) begin
            m_active <= 1'b1;
            m_key    <= key;
            m_e_init <= cyc + 1;
            m_e_ksa  <= cyc + 1 + 2 + B_INIT;
            m_e_prga <= cyc + 1 + 2 + B_INIT + 2 + D_KSA + B_KSA;
            m_e_done <= cyc + 1 + 2 + B_INIT + 2 + D_KSA + B_KSA + 2 + B_PRGA;
        end
        cyc <= cyc + 1;
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            logic [1:0] ep;
            logic [7:0] ea, ed;
            ep = 2'd0;
            if (m_active) begin
                if (cyc >= m_e_init && cyc < m_e_ksa) ep = 2'd1;
                else if (cyc >= m_e_ksa && cyc < m_e_prga) ep = 2'd2;
                else if (cyc >= m_e_prga && cyc < m_e_done) ep = 2'd3;
            end
            case (ep)
                2'd1:    begin ea = 8'h11; ed = 8'hA1; end
                2'd2:    begin ea = 8'h22; ed = 8'hB2; end
                2'd3:    begin ea = 8'h33; ed = 8'hC3; end
                default: begin ea = 8'h00; ed = 8'h00; end
            endcase
            check("phase",    32'(phase),    32'(ep));
            check("rdy",      32'(rdy),      32'(m_idle(cyc)));
            check("done",     32'(done),     32'(m_active && cyc == m_e_done));
            check("init_en",  32'(init_en),  32'(m_active && cyc == m_e_init));
            check("ksa_en",   32'(ksa_en),   32'(m_active && cyc == m_e_ksa));
            check("prga_en",  32'(prga_en),  32'(m_active && cyc == m_e_prga));
            check("key_q",    32'(key_q),    32'(m_key));
            check("s_addr",   32'(s_addr),   32'(ea));
            check("s_wrdata", 32'(s_wrdata), 32'(ed));
            check("s_wren",   32'(s_wren),   32'(ep != 2'd0));
            check("err",      32'(err),      32'd0);
        end
    end

    // Actual pulse bookkeeping per run.
    int n_init, n_ksa, n_prga, n_done;
    int c_init, c_ksa, c_prga, c_done;

    always @(negedge clk) begin
        if (init_en) begin n_init++; c_init = cyc; end
        if (ksa_en)  begin n_ksa++;  c_ksa  = cyc; end
        if (prga_en) begin n_prga++; c_prga = cyc; end
        if (done)    begin n_done++; c_done = cyc; end
    end

    task automatic clear_counts();
        n_init = 0; n_ksa = 0; n_prga = 0; n_done = 0;
        c_init = 0; c_ksa = 0; c_prga = 0; c_done = 0;
    endtask

    task automatic start_run(input logic [23:0] k);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        key   = '0;
        clear_counts();
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_rdy",      32'(rdy),      32'd1);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_phase",    32'(phase),    32'd0);
        check("rst_en_any",   32'({init_en, ksa_en, prga_en}), 32'd0);
        check("rst_key_q",    32'(key_q),    32'd0);
        check("rst_s_wren",   32'(s_wren),   32'd0);
        check("rst_s_addr",   32'(s_addr),   32'd0);
        check("rst_s_wrdata", 32'(s_wrdata), 32'd0);

        rst_n  = 1'b1;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: full sequence, ignored en + key change during WAIT_KSA.
        clear_counts();
        start_run(24'h000311);
        repeat (B_INIT + 20) @(negedge clk);
        check("mid_phase_ksa", 32'(phase), 32'd2);
        key = 24'hFFFFFF;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("key_q_hold", 32'(key_q), 32'h000311);
        wait_done(B_INIT + B_KSA + B_PRGA + 100, "run1_done_seen");
        @(negedge clk);
        check("run1_rdy_after_done", 32'(rdy), 32'd1);
        check("run1_init_cnt", 32'(n_init), 32'd1);
        check("run1_ksa_cnt",  32'(n_ksa),  32'd1);
        check("run1_prga_cnt", 32'(n_prga), 32'd1);
        check("run1_done_cnt", 32'(n_done), 32'd1);
        check("run1_ksa_lat",  32'(c_ksa  - c_init), 32'(LIT_KSA));
        check("run1_prga_lat", 32'(c_prga - c_init), 32'(LIT_PRGA));
        check("run1_done_lat", 32'(c_done - c_init), 32'(LIT_DONE));
        key = 24'h000000;
        repeat (3) @(negedge clk);

        // Run 2: reset for one cycle during WAIT_INIT, then a fresh start.
        clear_counts();
        start_run(24'hABCDEF);
        repeat (10) @(negedge clk);
        check("run2_phase_init", 32'(phase), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("run2_rst_rdy",    32'(rdy),    32'd1);
        check("run2_rst_phase",  32'(phase),  32'd0);
        check("run2_rst_s_wren", 32'(s_wren), 32'd0);
        repeat (5) @(negedge clk);
        check("run2_no_ksa", 32'(n_ksa), 32'd0);

        clear_counts();
        start_run(24'h5A5A5A);
        wait_done(B_INIT + B_KSA + B_PRGA + 100, "run3_done_seen");
        @(negedge clk);
        check("run3_init_cnt", 32'(n_init), 32'd1);
        check("run3_prga_cnt", 32'(n_prga), 32'd1);
        check("run3_key_q",    32'(key_q),  32'h5A5A5A);
        check("run3_done_lat", 32'(c_done - c_init), 32'(LIT_DONE));
        repeat (3) @(negedge clk);

`ifdef ARC4_SCHED_WDOG_EN
        // Watchdog: prga never completes.
        begin
            int i;
            cmp_on    = 1'b0;
            prga_hang = 1'b1;
            clear_counts();
            start_run(24'h123456);
            i = 0;
            while (!prga_en && i < 500) begin
                @(negedge clk);
                i++;
            end
            check("wd_prga_en_seen", 32'(prga_en), 32'd1);
            repeat (100) @(negedge clk);
            check("wd_err_not_yet", 32'(err), 32'd0);
            @(negedge clk);
            check("wd_err",    32'(err),    32'd1);
            check("wd_rdy",    32'(rdy),    32'd0);
            check("wd_phase",  32'(phase),  32'd0);
            check("wd_s_wren", 32'(s_wren), 32'd0);
            repeat (50) @(negedge clk);
            check("wd_err_sticky", 32'(err), 32'd1);
            check("wd_rdy_held",   32'(rdy), 32'd0);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            prga_hang = 1'b0;
            check("wd_rst_err", 32'(err), 32'd0);
            check("wd_rst_rdy", 32'(rdy), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
